// File: rtl/cfa_pkg.sv
// Shared definitions for the digit-serial add/subtract unit.
package cfa_pkg;

  // Controller states; in_ready is IDLE, out_valid is DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Legal geometry: at least 2 bits wide, whole number of digits.
  function automatic bit digit_cfg_ok(input int unsigned width, input int unsigned digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/adder_digit.sv
// DIGIT-wide ripple of 1-bit full-adder cells, one digit of the serial adder.
module adder_digit
  import cfa_pkg::*;
#(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             ci,
  output logic [DIGIT-1:0] s_d,
  output logic             co,
  output logic             c_msb
);

  logic       cy;
  logic [1:0] fa;

  // Ripple the carry through the cells; c_msb is the carry entering the top cell.
  always_comb begin
    s_d   = '0;
    cy    = ci;
    c_msb = ci;
    fa    = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      c_msb  = cy;
      fa     = full_add(a_d[i], b_d[i], cy);
      s_d[i] = fa[0];
      cy     = fa[1];
    end
    co = cy;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed LSB-first, DIGIT bits per cycle.
module digit_serial_adder
  import cfa_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!digit_cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
    $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_c_msb;

  // Operand registers shift right each RUN cycle, so the current digit is always the low slice.
  adder_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a_d  (a_q[DIGIT-1:0]),
    .b_d  (b_q[DIGIT-1:0]),
    .ci   (carry_q),
    .s_d  (dig_s),
    .co   (dig_co),
    .c_msb(dig_c_msb)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction is a + ~b + 1; the +1 rides in as the initial carry.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the top; after NDIG shifts the LSB digit sits at the bottom.
        acc_d   = (acc_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
        carry_d = dig_co;
        if (cnt_q == CW'(NDIG - 1)) begin
          s_d     = acc_d;
          c_d     = dig_co;
          ovf_d   = dig_c_msb ^ dig_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c         = c_q;
  assign ovf       = ovf_q;

endmodule
